tcm_lsu_port: RTL and testbench



---
 rtl/mem_defines.sv | 8 +
 rtl/tcm_load_align.sv | 15 +
 rtl/tcm_lsu_port.sv | 91 +++++++++
 tb/tb_tcm_lsu_port.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_defines.sv
// mem_defines: shared access-size and response-state types plus strobe helper for the TCM LSU port
package mem_defines;
   typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2} mem_size_t;
   typedef enum logic [1:0] {EMPTY, LIVE, HELD} tcm_lsu_state_t;
   function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
      return size == SIZE_B ? 4'b0001 << addr_lo : size == SIZE_H ? 4'b0011 << addr_lo : 4'b1111;
   endfunction
endpackage

// File: rtl/tcm_load_align.sv
// tcm_load_align: selects the addressed lane of a RAM word and sign/zero extends it
module tcm_load_align
   import mem_defines::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        zext,
   output logic [31:0] data
);
   logic [31:0] s;
   assign s = rdata >> {addr_lo, 3'b000};
   assign data = size == SIZE_B ? {{24{~zext & s[7]}}, s[7:0]} :
                 size == SIZE_H ? {{16{~zext & s[15]}}, s[15:0]} : rdata;
endmodule

// File: rtl/tcm_lsu_port.sv
// tcm_lsu_port: LSU request to TCM RAM port initiator with one-cycle read response and stall hold
module tcm_lsu_port
   import mem_defines::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [31:0]           resp_rdata_o,
   output logic                  resp_err_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]            mem_wr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i
);
   tcm_lsu_state_t state;
   logic accept, err, wr_go;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0] addr_lo_q, size_q;
   logic zext_q, we_q, err_q, hold_err;
   logic [31:0] aligned, live_data, hold_data;
   assign err = req_size_i == 2'd3 || (req_size_i == SIZE_H && req_addr_i[0]) ||
                (req_size_i == SIZE_W && req_addr_i[1:0] != 2'b00);
   assign resp_valid_o = !rst_i && state != EMPTY;
   assign req_ready_o = !rst_i && state != HELD && (!resp_valid_o || resp_ready_i);
   assign accept = req_valid_i && req_ready_o;
   assign wr_go = accept && req_we_i && !err;
   assign mem_addr_o = rst_i ? '0 : accept ? {2'b00, req_addr_i[ADDR_WIDTH-1:2]} : addr_q;
   assign mem_wr_o = wr_go ? be_gen(req_size_i, req_addr_i[1:0]) : 4'b0000;
   assign mem_wdata_o = !wr_go ? 32'h0 :
                        req_size_i == SIZE_B ? {4{req_wdata_i[7:0]}} :
                        req_size_i == SIZE_H ? {2{req_wdata_i[15:0]}} : req_wdata_i;
   assign live_data = (we_q || err_q) ? 32'h0 : aligned;
   assign resp_rdata_o = !resp_valid_o ? 32'h0 : state == HELD ? hold_data : live_data;
   assign resp_err_o = resp_valid_o && (state == HELD ? hold_err : err_q);

   tcm_load_align u_align (
      .rdata   (mem_rdata_i),
      .addr_lo (addr_lo_q),
      .size    (size_q),
      .zext    (zext_q),
      .data    (aligned)
   );

   // capture request attributes needed when the RAM data returns next cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q    <= '0;
         addr_lo_q <= 2'b00;
         size_q    <= 2'b00;
         zext_q    <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
      end else if (accept) begin
         addr_q    <= {2'b00, req_addr_i[ADDR_WIDTH-1:2]};
         addr_lo_q <= req_addr_i[1:0];
         size_q    <= req_size_i;
         zext_q    <= req_unsigned_i;
         we_q      <= req_we_i;
         err_q     <= err;
      end
   end

   // freeze a stalled response since the other RAM port may overwrite the word meanwhile
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_data <= 32'h0;
         hold_err  <= 1'b0;
      end else if (state == LIVE && !resp_ready_i) begin
         hold_data <= live_data;
         hold_err  <= err_q;
      end
   end

   // response state: EMPTY -> LIVE on accept, LIVE -> HELD on stall, HELD drains to EMPTY
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= EMPTY;
      else state <= state == HELD ? (resp_ready_i ? EMPTY : HELD) :
                    (state == LIVE && !resp_ready_i) ? HELD :
                    accept ? LIVE : EMPTY;
   end
endmodule

// File: tb/tb_tcm_lsu_port.sv
// tb_tcm_lsu_port: scoreboard bench for tcm_lsu_port against a read-first dual-port RAM model
module tb_tcm_lsu_port;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [15:0] req_addr_i = '0;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'd0;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_wdata_i = '0;
   logic        resp_valid_o;
   logic        resp_ready_i = 1'b1;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic [15:0] mem_addr_o;
   logic [3:0]  mem_wr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   logic        b_we = 1'b0;
   logic [15:0] b_addr = '0;
   logic [31:0] b_data = '0;
   logic [31:0] ram [65536];
   int          dut_writes = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          stalls = 0;
   logic [32:0] sb [$];

   tcm_lsu_port #(.ADDR_WIDTH(16)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_addr_i     (req_addr_i),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_wdata_i    (req_wdata_i),
      .resp_valid_o   (resp_valid_o),
      .resp_ready_i   (resp_ready_i),
      .resp_rdata_o   (resp_rdata_o),
      .resp_err_o     (resp_err_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wr_o       (mem_wr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rdata_i    (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // read-first RAM: registered read of the old word, byte-lane writes from the DUT, word writes from port B
   always @(posedge clk_i) begin
      mem_rdata_i <= ram[mem_addr_o];
      for (int k = 0; k < 4; k++)
         if (mem_wr_o[k]) ram[mem_addr_o][8*k +: 8] <= mem_wdata_o[8*k +: 8];
      if (|mem_wr_o) dut_writes <= dut_writes + 1;
      if (b_we) ram[b_addr] <= b_data;
   end

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every response handshake is compared against the oldest expectation
   always @(negedge clk_i) begin
      if (!rst_i && resp_valid_o && resp_ready_i) begin
         if (sb.size() == 0) chk(1'b0, "resp_unexpected", resp_rdata_o, 32'h0);
         else begin
            logic [32:0] e;
            e = sb.pop_front();
            chk(resp_err_o == e[32], "resp_err", {31'h0, resp_err_o}, {31'h0, e[32]});
            chk(resp_rdata_o == e[31:0], "resp_rdata", resp_rdata_o, e[31:0]);
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] wd, input logic [3:0] ewr, input logic [31:0] ewd,
                        input logic eerr, input logic [31:0] erd);
      int w = 0;
      req_valid_i = 1'b1;
      req_addr_i = a;
      req_we_i = we;
      req_size_i = sz;
      req_unsigned_i = uns;
      req_wdata_i = wd;
      #1;
      while (!req_ready_o && w < 20) begin
         @(posedge clk_i);
         #1;
         w++;
      end
      stalls += w;
      if (!req_ready_o) chk(1'b0, "issue_timeout", {16'h0, a}, 32'h0);
      else begin
         chk(mem_wr_o == ewr, "mem_wr", {28'h0, mem_wr_o}, {28'h0, ewr});
         chk(mem_addr_o == {2'b00, a[15:2]}, "mem_addr", {16'h0, mem_addr_o}, {18'h0, a[15:2]});
         if (ewr != 4'h0) chk(mem_wdata_o == ewd, "mem_wdata", mem_wdata_o, ewd);
         sb.push_back({eerr, erd});
      end
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
   endtask

   initial begin
      int w0;
      b_we = 1'b1;
      b_addr = 16'h0080;
      b_data = 32'hCAFEF00D;
      @(posedge clk_i);
      #1;
      b_we = 1'b0;
      @(posedge clk_i);
      #1;
      chk(req_ready_o == 1'b0, "rst_req_ready", {31'h0, req_ready_o}, 32'h0);
      chk(resp_valid_o == 1'b0, "rst_resp_valid", {31'h0, resp_valid_o}, 32'h0);
      chk(mem_addr_o == 16'h0, "rst_mem_addr", {16'h0, mem_addr_o}, 32'h0);
      chk(mem_wr_o == 4'h0 && mem_wdata_o == 32'h0, "rst_mem_wr", {28'h0, mem_wr_o}, 32'h0);
      rst_i = 1'b0;
      #1;
      chk(req_ready_o == 1'b1, "post_rst_ready", {31'h0, req_ready_o}, 32'h1);
      @(posedge clk_i);
      #1;

      issue(16'h0100, 1, 2'd2, 0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 0, 32'h0);
      issue(16'h0100, 0, 2'd2, 0, 32'h0, 4'h0, 32'h0, 0, 32'hDEADBEEF);
      issue(16'h0103, 1, 2'd0, 0, 32'h00000080, 4'b1000, 32'h80808080, 0, 32'h0);
      issue(16'h0103, 0, 2'd0, 0, 32'h0, 4'h0, 32'h0, 0, 32'hFFFFFF80);
      issue(16'h0103, 0, 2'd0, 1, 32'h0, 4'h0, 32'h0, 0, 32'h00000080);

      @(posedge clk_i);
      #1;
      w0 = dut_writes;
      issue(16'h0101, 0, 2'd1, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0);
      issue(16'h0102, 1, 2'd2, 0, 32'hFFFFFFFF, 4'h0, 32'h0, 1, 32'h0);
      issue(16'h0100, 1, 2'd3, 0, 32'hFFFFFFFF, 4'h0, 32'h0, 1, 32'h0);
      @(posedge clk_i);
      #1;
      chk(dut_writes == w0, "err_no_write", dut_writes, w0);
      issue(16'h0100, 0, 2'd2, 0, 32'h0, 4'h0, 32'h0, 0, 32'h80ADBEEF);
      @(posedge clk_i);
      #1;

      resp_ready_i = 1'b0;
      issue(16'h0200, 0, 2'd2, 0, 32'h0, 4'h0, 32'h0, 0, 32'hCAFEF00D);
      b_we = 1'b1;
      b_addr = 16'h0080;
      b_data = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         chk(req_ready_o == 1'b0, "stall_req_ready", {31'h0, req_ready_o}, 32'h0);
         chk(resp_valid_o == 1'b1, "stall_resp_valid", {31'h0, resp_valid_o}, 32'h1);
         chk(resp_rdata_o == 32'hCAFEF00D, "stall_rdata", resp_rdata_o, 32'hCAFEF00D);
         @(posedge clk_i);
         #1;
         b_we = 1'b0;
      end
      chk(mem_rdata_i == 32'h12345678, "ram_overwritten", mem_rdata_i, 32'h12345678);
      resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk(req_ready_o == 1'b1 && resp_valid_o == 1'b0, "drain_empty", {30'h0, req_ready_o, resp_valid_o}, 32'h2);

      stalls = 0;
      issue(16'h0300, 1, 2'd2, 0, 32'h11223344, 4'hF, 32'h11223344, 0, 32'h0);
      issue(16'h0300, 0, 2'd2, 0, 32'h0, 4'h0, 32'h0, 0, 32'h11223344);
      issue(16'h0302, 1, 2'd1, 0, 32'h0000A5B6, 4'b1100, 32'hA5B6A5B6, 0, 32'h0);
      issue(16'h0302, 0, 2'd1, 0, 32'h0, 4'h0, 32'h0, 0, 32'hFFFFA5B6);
      issue(16'h0301, 0, 2'd0, 1, 32'h0, 4'h0, 32'h0, 0, 32'h00000033);
      issue(16'h0300, 1, 2'd0, 0, 32'h0000007F, 4'b0001, 32'h7F7F7F7F, 0, 32'h0);
      issue(16'h0300, 0, 2'd2, 0, 32'h0, 4'h0, 32'h0, 0, 32'hA5B6337F);
      issue(16'h0300, 0, 2'd1, 1, 32'h0, 4'h0, 32'h0, 0, 32'h0000337F);
      chk(stalls == 0, "burst_stalls", stalls, 0);
      @(posedge clk_i);
      #1;

      resp_ready_i = 1'b0;
      issue(16'h0100, 0, 2'd2, 0, 32'h0, 4'h0, 32'h0, 0, 32'h80ADBEEF);
      @(posedge clk_i);
      #1;
      chk(req_ready_o == 1'b0 && resp_valid_o == 1'b1, "held_before_rst", {30'h0, req_ready_o, resp_valid_o}, 32'h1);
      rst_i = 1'b1;
      #1;
      chk(resp_valid_o == 1'b0, "rst_held_valid", {31'h0, resp_valid_o}, 32'h0);
      chk(mem_wr_o == 4'h0 && req_ready_o == 1'b0, "rst_held_wr", {27'h0, req_ready_o, mem_wr_o}, 32'h0);
      @(posedge clk_i);
      #1;
      sb.delete();
      rst_i = 1'b0;
      resp_ready_i = 1'b1;
      #1;
      chk(resp_valid_o == 1'b0 && req_ready_o == 1'b1, "post_rst_empty", {30'h0, req_ready_o, resp_valid_o}, 32'h2);
      chk(mem_addr_o == 16'h0, "post_rst_addr", {16'h0, mem_addr_o}, 32'h0);

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk_i);
      #1;
      chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
